maxnet_host_driver: RTL and testbench

Initiator-side sequencer for the Maxnet core. Accepts a packed input vector from the host, writes it element by element into the core's input memory, and pulses `start_signal`. It then waits for the core's `ready` and scans the core's final activations to find the winner. The winner index and value are returned to the host over a valid/ready result channel.

---
 rtl/maxnet_defs.sv | 22 ++
 rtl/maxnet_argmax_scan.sv | 78 +++++++
 rtl/maxnet_host_driver.sv | 166 ++++++++++++++++
 tb/tb_maxnet_host_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_defs.sv
// rtl/maxnet_defs.sv - shared Maxnet definitions: driver state encoding and default sizes
package maxnet_defs;

    localparam int MAXNET_N           = 4;
    localparam int MAXNET_DW          = 16;
    localparam int MAXNET_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SCAN  = 3'd4,
        ST_HOLD  = 3'd5
    } maxnet_state_t;

    // Positive-element counter only needs to distinguish 0, 1 and "2 or more".
    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'd2) ? c : c + 2'd1;
    endfunction

endpackage

// File: rtl/maxnet_argmax_scan.sv
// rtl/maxnet_argmax_scan.sv - snapshots core activations and finds the signed maximum one element per step
module maxnet_argmax_scan
    import maxnet_defs::*;
#(
    parameter int N    = MAXNET_N,
    parameter int DW   = MAXNET_DW,
    parameter int IDXW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    output logic                 last,
    input  logic [N*DW-1:0]      core_val,
    output logic [IDXW-1:0]      max_idx,
    output logic [DW-1:0]        max_val,
    output logic [1:0]           pos_cnt
);

    logic [N*DW-1:0]        snap_q, snap_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic [IDXW-1:0]        max_idx_q, max_idx_d;
    logic signed [DW-1:0]   max_val_q, max_val_d;
    logic [1:0]             cnt_q, cnt_d;
    logic signed [DW-1:0]   elem;
    logic                   elem_pos;
    logic                   first;

    assign elem     = snap_q[idx_q*DW +: DW];
    assign elem_pos = !elem[DW-1] && (elem != '0);
    assign first    = (idx_q == '0);
    assign last     = (idx_q == IDXW'(N-1));

    always_comb begin
        snap_d    = snap_q;
        idx_d     = idx_q;
        max_idx_d = max_idx_q;
        max_val_d = max_val_q;
        cnt_d     = cnt_q;
        if (load) begin
            snap_d = core_val;
            idx_d  = '0;
        end else if (step) begin
            // Strictly-greater replacement keeps the lowest index on equal maxima.
            if (first || (elem > max_val_q)) begin
                max_val_d = elem;
                max_idx_d = idx_q;
            end
            if (first)
                cnt_d = {1'b0, elem_pos};
            else if (elem_pos)
                cnt_d = sat_inc2(cnt_q);
            if (!last)
                idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q    <= '0;
            idx_q     <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
            cnt_q     <= '0;
        end else begin
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            max_idx_q <= max_idx_d;
            max_val_q <= max_val_d;
            cnt_q     <= cnt_d;
        end
    end

    assign max_idx = max_idx_q;
    assign max_val = max_val_q;
    assign pos_cnt = cnt_q;

endmodule

// File: rtl/maxnet_host_driver.sv
// rtl/maxnet_host_driver.sv - Maxnet initiator: load input memory, start core, scan winner, return result
// Optional WAIT-state watchdog enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_host_driver
    import maxnet_defs::*;
#(
    parameter int N           = MAXNET_N,
    parameter int DW          = MAXNET_DW,
    parameter int IDXW        = $clog2(N),
    parameter int TIMEOUT_CYC = MAXNET_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [N*DW-1:0]      in_data,
    output logic                 mem_we,
    output logic [IDXW-1:0]      mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 start_signal,
    input  logic                 ready,
    input  logic [N*DW-1:0]      core_val,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [IDXW-1:0]      res_idx,
    output logic [DW-1:0]        res_val,
    output logic                 res_none,
    output logic                 res_tie,
    output logic                 timeout,
    output logic                 busy
);

    maxnet_state_t          state_q, state_d;
    logic [N*DW-1:0]        in_q, in_d;
    logic [IDXW-1:0]        ld_cnt_q, ld_cnt_d;
    logic                   scan_load;
    logic                   scan_step;
    logic                   scan_last;
    logic [IDXW-1:0]        scan_idx;
    logic [DW-1:0]          scan_val;
    logic [1:0]             scan_cnt;
    logic                   timeout_int;
    logic                   hold_ok;

`ifdef MAXNET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]          wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   wait_expired;
    assign wait_expired = (wait_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign timeout_int  = timeout_q;
`else
    assign timeout_int  = 1'b0;
`endif

    assign scan_load = (state_q == ST_WAIT) && ready;
    assign scan_step = (state_q == ST_SCAN);

    always_comb begin
        state_d  = state_q;
        in_d     = in_q;
        ld_cnt_d = ld_cnt_q;
`ifdef MAXNET_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    in_d     = in_data;
                    ld_cnt_d = '0;
`ifdef MAXNET_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_cnt_q == IDXW'(N-1)) begin
                    ld_cnt_d = '0;
                    state_d  = ST_START;
                end else begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end
            ST_START: begin
`ifdef MAXNET_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready) begin
                    state_d = ST_SCAN;
`ifdef MAXNET_TIMEOUT_EN
                end else if (wait_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            ST_SCAN: begin
                if (scan_last)
                    state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            in_q     <= '0;
            ld_cnt_q <= '0;
`ifdef MAXNET_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            in_q     <= in_d;
            ld_cnt_q <= ld_cnt_d;
`ifdef MAXNET_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    maxnet_argmax_scan #(
        .N    (N),
        .DW   (DW),
        .IDXW (IDXW)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .load     (scan_load),
        .step     (scan_step),
        .last     (scan_last),
        .core_val (core_val),
        .max_idx  (scan_idx),
        .max_val  (scan_val),
        .pos_cnt  (scan_cnt)
    );

    // Every output is a decode of registered state; the result fields read zero outside HOLD.
    assign hold_ok      = (state_q == ST_HOLD) && !timeout_int;
    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign mem_we       = (state_q == ST_LOAD);
    assign mem_addr     = mem_we ? ld_cnt_q : '0;
    assign mem_wdata    = mem_we ? in_q[ld_cnt_q*DW +: DW] : '0;
    assign start_signal = (state_q == ST_START);
    assign res_valid    = (state_q == ST_HOLD);
    assign res_idx      = hold_ok ? scan_idx : '0;
    assign res_val      = hold_ok ? scan_val : '0;
    assign res_none     = (state_q == ST_HOLD) && (timeout_int || (scan_cnt == 2'd0));
    assign res_tie      = hold_ok && (scan_cnt == 2'd2);
    assign timeout      = timeout_int;

endmodule

// File: tb/tb_maxnet_host_driver.sv
// tb/tb_maxnet_host_driver.sv - directed table-driven bench for maxnet_host_driver (N=4, DW=16)
module tb_maxnet_host_driver;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   in_data;
    logic          mem_we;
    logic [1:0]    mem_addr;
    logic [15:0]   mem_wdata;
    logic          start_signal;
    logic          ready;
    logic [63:0]   core_val;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_idx;
    logic [15:0]   res_val;
    logic          res_none;
    logic          res_tie;
    logic          timeout;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    maxnet_host_driver #(.N(N), .DW(DW), .TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .in_data      (in_data),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .start_signal (start_signal),
        .ready        (ready),
        .core_val     (core_val),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_idx      (res_idx),
        .res_val      (res_val),
        .res_none     (res_none),
        .res_tie      (res_tie),
        .timeout      (timeout),
        .busy         (busy)
    );

    typedef struct {
        logic [63:0] in_data;
        logic [63:0] core_val;
        logic [1:0]  idx;
        logic [15:0] val;
        logic        none;
        logic        tie;
    } vec_t;

    vec_t vecs[6];
    localparam logic [63:0] DECOY = {4{16'h0100}};

    function automatic logic [63:0] pk(input logic [15:0] e0, input logic [15:0] e1,
                                       input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 1);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_start"}, 32'(start_signal), 0);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_res_none"}, 32'(res_none), 0);
        chk({tag, "_res_tie"}, 32'(res_tie), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_res_idx"}, 32'(res_idx), 0);
        chk({tag, "_res_val"}, 32'(res_val), 0);
    endtask

    // Called at a negedge in IDLE; returns at a negedge in IDLE after the handshake.
    task automatic do_run(input vec_t v, input int rdly, input int hold_wait);
        logic [15:0] el;
        logic        scan_bad;
        chk("pre_req_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        in_data   = v.in_data;
        @(negedge clk);
        req_valid = 1'b0;
        in_data   = '1;
        for (int k = 0; k < N; k++) begin
            el = v.in_data[k*DW +: DW];
            chk("load_we", 32'(mem_we), 1);
            chk("load_addr", 32'(mem_addr), 32'(k));
            chk("load_wdata", 32'(mem_wdata), 32'(el));
            @(negedge clk);
        end
        chk("start_pulse", 32'(start_signal), 1);
        chk("start_we_low", 32'(mem_we), 0);
        ready    = 1'b1;
        core_val = DECOY;
        @(negedge clk);
        ready = 1'b0;
        chk("start_one_cycle", 32'(start_signal), 0);
        for (int i = 0; i < rdly - 1; i++) @(negedge clk);
        ready    = 1'b1;
        core_val = v.core_val;
        @(negedge clk);
        ready    = 1'b0;
        core_val = DECOY;
        scan_bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (res_valid !== 1'b0 || busy !== 1'b1) scan_bad = 1'b1;
            @(negedge clk);
        end
        chk("scan_no_valid", 32'(scan_bad), 0);
        chk("res_valid", 32'(res_valid), 1);
        chk("res_idx", 32'(res_idx), 32'(v.idx));
        chk("res_val", 32'(res_val), 32'(v.val));
        chk("res_none", 32'(res_none), 32'(v.none));
        chk("res_tie", 32'(res_tie), 32'(v.tie));
        for (int i = 0; i < hold_wait; i++) begin
            res_ready = 1'b0;
            if (i == 0) begin
                req_valid = 1'b1;
                in_data   = pk(16'h1111, 16'h2222, 16'h3333, 16'h4444);
            end
            @(negedge clk);
            req_valid = 1'b0;
            chk("hold_valid", 32'(res_valid), 1);
            chk("hold_idx", 32'(res_idx), 32'(v.idx));
            chk("hold_val", 32'(res_val), 32'(v.val));
            chk("hold_flags", {30'd0, res_none, res_tie}, {30'd0, v.none, v.tie});
            chk("hold_no_accept", {30'd0, req_ready, mem_we}, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_valid_low", 32'(res_valid), 0);
        chk("post_req_ready", 32'(req_ready), 1);
        chk("post_no_load", 32'(mem_we), 0);
    endtask

    initial begin
        logic start_seen;

        vecs[0] = '{pk(16'd10, 16'd40, 16'd20, 16'd30), pk(16'd0, 16'd5, 16'd0, 16'd0), 2'd1, 16'd5, 1'b0, 1'b0};
        vecs[1] = '{pk(16'd1, 16'd2, 16'd3, 16'd4), pk(16'd0, 16'd0, 16'd0, 16'd0), 2'd0, 16'd0, 1'b1, 1'b0};
        vecs[2] = '{pk(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0), pk(16'd7, 16'd3, 16'd7, 16'd0), 2'd0, 16'd7, 1'b0, 1'b1};
        vecs[3] = '{pk(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001), pk(16'hFFFB, 16'hFFFE, 16'hFFF7, 16'hFFFE), 2'd1, 16'hFFFE, 1'b1, 1'b0};
        vecs[4] = '{pk(16'd9, 16'd8, 16'd7, 16'd6), pk(16'hFFFF, 16'd0, 16'd0, 16'd100), 2'd3, 16'd100, 1'b0, 1'b0};
        vecs[5] = '{pk(16'd0, 16'd0, 16'd0, 16'd0), pk(16'h7FFF, 16'h8000, 16'd1, 16'd0), 2'd0, 16'h7FFF, 1'b0, 1'b1};

        rst       = 1'b1;
        req_valid = 1'b0;
        in_data   = '0;
        ready     = 1'b0;
        core_val  = '0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        start_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (start_signal !== 1'b0 || req_ready !== 1'b1) start_seen = 1'b1;
        end
        chk("idle_50_quiet", 32'(start_seen), 0);

        for (int i = 0; i < 6; i++)
            do_run(vecs[i], (i == 0) ? 5 : i, 0);

        do_run(vecs[4], 3, 10);

        // Reset while waiting on the core.
        req_valid = 1'b1;
        in_data   = vecs[0].in_data;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (N + 3) @(negedge clk);
        chk("wait_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        do_run(vecs[0], 5, 0);

`ifdef MAXNET_TIMEOUT_EN
        req_valid = 1'b1;
        in_data   = vecs[2].in_data;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (N + 16) @(negedge clk);
        chk("tmo_not_yet", 32'(res_valid), 0);
        @(negedge clk);
        chk("tmo_valid", 32'(res_valid), 1);
        chk("tmo_flag", 32'(timeout), 1);
        chk("tmo_idx", 32'(res_idx), 0);
        chk("tmo_val", 32'(res_val), 0);
        chk("tmo_none", 32'(res_none), 1);
        chk("tmo_tie", 32'(res_tie), 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("tmo_idle_flag", 32'(timeout), 1);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("tmo_clear_on_accept", 32'(timeout), 0);
`else
        req_valid = 1'b1;
        in_data   = vecs[2].in_data;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2000) @(negedge clk);
        chk("notmo_busy", 32'(busy), 1);
        chk("notmo_flag", 32'(timeout), 0);
        chk("notmo_valid", 32'(res_valid), 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("final_idle", 32'(req_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
